instr_encoder: RTL



---
 rtl/instr_encoder_if.sv | 34 +++
 rtl/instr_encoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request, address-load and instruction-memory write signals of instr_encoder.
// master = requester/memory side (testbench), slave = the encoder itself.
interface instr_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        addr_load;
    logic [9:0]  addr_in;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        err;
    logic        wrapped;

    modport master (
        output req_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output addr_load, addr_in, mem_ack,
        input  req_ready, mem_we, mem_addr, mem_wdata, err, wrapped
    );

    modport slave (
        input  req_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  addr_load, addr_in, mem_ack,
        output req_ready, mem_we, mem_addr, mem_wdata, err, wrapped
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I/S/B instruction fields into a 32-bit word and writes it to instruction memory.
// Optional immediate range checking is enabled with macro IMM_RANGE_CHECK_EN.
module instr_encoder (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus,
    output logic [1:0]      state_dbg
);
    // Handshakes: a request transfers on a cycle where req_valid=1 and req_ready=1;
    // a memory write is held (mem_we/mem_addr/mem_wdata stable) until the cycle mem_ack=1.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ENCODE = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;

    localparam logic [1:0] FMT_R = 2'b00;
    localparam logic [1:0] FMT_I = 2'b01;
    localparam logic [1:0] FMT_S = 2'b10;

`ifdef IMM_RANGE_CHECK_EN
    localparam int IMM_W = 32;
`else
    localparam int IMM_W = 13;  // silent truncation needs only imm[12:0]
`endif

    logic [1:0]       state;
    logic [9:0]       ptr;
    logic [31:0]      wdata;
    logic             wrapped_q;
    logic [1:0]       fmt_q;
    logic [6:0]       opcode_q;
    logic [4:0]       rd_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [2:0]       funct3_q;
    logic [6:0]       funct7_q;
    logic [IMM_W-1:0] imm_q;
    logic [31:0]      enc;
    logic             reject;

    always_comb begin
        enc = 32'd0;
        case (fmt_q)
            FMT_R:   enc = {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q};
            FMT_I:   enc = {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q};
            FMT_S:   enc = {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q};
            default: enc = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q,
                            imm_q[4:1], imm_q[11], opcode_q};
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic err_q;

    always_comb begin
        reject = 1'b0;
        case (fmt_q)
            FMT_R:   reject = 1'b0;
            FMT_I,
            FMT_S:   reject = ($signed(imm_q) < -32'sd2048) || ($signed(imm_q) > 32'sd2047);
            default: reject = ($signed(imm_q) < -32'sd4096) || ($signed(imm_q) > 32'sd4094)
                              || imm_q[0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= (state == ENCODE) && reject;
    end

    assign bus.err = err_q;
`else
    assign reject  = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 10'd0;
            wdata     <= 32'd0;
            wrapped_q <= 1'b0;
            fmt_q     <= 2'd0;
            opcode_q  <= 7'd0;
            rd_q      <= 5'd0;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            funct3_q  <= 3'd0;
            funct7_q  <= 7'd0;
            imm_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A load coinciding with an accepted request retargets that request.
                    if (bus.addr_load)
                        ptr <= bus.addr_in;
                    if (bus.req_valid) begin
                        fmt_q    <= bus.fmt;
                        opcode_q <= bus.opcode;
                        rd_q     <= bus.rd;
                        rs1_q    <= bus.rs1;
                        rs2_q    <= bus.rs2;
                        funct3_q <= bus.funct3;
                        funct7_q <= bus.funct7;
                        imm_q    <= bus.imm[IMM_W-1:0];
                        state    <= ENCODE;
                    end
                end
                ENCODE: begin
                    if (reject) begin
                        state <= IDLE;
                    end else begin
                        wdata <= enc;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        ptr   <= ptr + 10'd1;
                        state <= IDLE;
                        if (ptr == 10'd1023)
                            wrapped_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_we    = (state == WRITE);
    assign bus.mem_addr  = ptr;
    assign bus.mem_wdata = wdata;
    assign bus.wrapped   = wrapped_q;
    assign state_dbg     = state;
endmodule
